// File: rtl/barrel_ctrl.sv
// Sequential initiator for the 32-bit combinational barrel shifter: decodes requests, waits
// SETTLE cycles, registers the result. Optional flags outputs enabled by BARREL_CTRL_FLAGS_EN.

module barrel (
  input  logic [31:0] data_i,
  input  logic [7:0]  cmd_i,
  output logic [31:0] result_o
);
  logic [4:0] amt;
  logic       right, rot, arith;

  assign amt   = cmd_i[4:0];
  assign right = cmd_i[5];
  assign rot   = cmd_i[6];
  assign arith = cmd_i[7];

  // Five-stage logarithmic mux chain; stage i shifts by 2**i when amt[i] is set.
  always_comb begin
    logic [31:0] s;
    s = data_i;
    for (int i = 0; i < 5; i++) begin
      if (amt[i]) begin
        if (right) begin
          s = (s >> (1 << i)) |
              (rot ? (s << (32 - (1 << i))) :
               (arith && s[31]) ? ~({32{1'b1}} >> (1 << i)) : 32'h0);
        end else begin
          s = (s << (1 << i)) | (rot ? (s >> (32 - (1 << i))) : 32'h0);
        end
      end
    end
    result_o = s;
  end
endmodule

module barrel_ctrl #(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic [2:0]       in_op,
  input  logic [4:0]       in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_err,
  output logic [CNT_W-1:0] ops_done
`ifdef BARREL_CTRL_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_carry
`endif
);
  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  localparam logic [3:0] CntInit = 4'(SETTLE - 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [31:0]      opnd_q, opnd_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [31:0]      out_data_q, out_data_d;
  logic             out_err_q, out_err_d;
  logic [CNT_W-1:0] ops_done_q, ops_done_d;
  logic [31:0]      shift_res;
  logic [7:0]       cmd_enc;
  logic             op_legal;

  barrel u_barrel (
    .data_i  (opnd_q),
    .cmd_i   (cmd_q),
    .result_o(shift_res)
  );

  // Opcode to command byte: cmd[7]=arith, cmd[6]=rotate, cmd[5]=right.
  always_comb begin
    op_legal = 1'b1;
    cmd_enc  = 8'h00;
    case (in_op)
      3'b000:  cmd_enc = {3'b000, in_amt};
      3'b001:  cmd_enc = {3'b001, in_amt};
      3'b010:  cmd_enc = {3'b101, in_amt};
      3'b011:  cmd_enc = {3'b010, in_amt};
      3'b100:  cmd_enc = {3'b011, in_amt};
      default: op_legal = 1'b0;
    endcase
  end

`ifdef BARREL_CTRL_FLAGS_EN
  logic out_zero_q, out_zero_d;
  logic out_carry_q, out_carry_d;
  logic carry_calc;

  always_comb begin
    carry_calc = 1'b0;
    if (cmd_q[4:0] != 5'd0 && !cmd_q[6]) begin
      if (cmd_q[5]) carry_calc = opnd_q[cmd_q[4:0] - 5'd1];
      else          carry_calc = opnd_q[5'(6'd32 - {1'b0, cmd_q[4:0]})];
    end
  end

  assign out_zero  = out_zero_q;
  assign out_carry = out_carry_q;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    opnd_d     = opnd_q;
    cmd_d      = cmd_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;
    ops_done_d = ops_done_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
`ifdef BARREL_CTRL_FLAGS_EN
    out_zero_d  = out_zero_q;
    out_carry_d = out_carry_q;
`endif
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          opnd_d = in_data;
          cmd_d  = cmd_enc;
          if (op_legal) begin
            cnt_d   = CntInit;
            state_d = StWait;
          end else begin
            out_data_d = 32'h0;
            out_err_d  = 1'b1;
            state_d    = StDone;
`ifdef BARREL_CTRL_FLAGS_EN
            out_zero_d  = 1'b1;
            out_carry_d = 1'b0;
`endif
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          out_data_d = shift_res;
          out_err_d  = 1'b0;
          state_d    = StDone;
`ifdef BARREL_CTRL_FLAGS_EN
          out_zero_d  = (shift_res == 32'h0);
          out_carry_d = carry_calc;
`endif
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          ops_done_d = ops_done_q + 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      opnd_q     <= 32'h0;
      cmd_q      <= 8'h00;
      out_data_q <= 32'h0;
      out_err_q  <= 1'b0;
      ops_done_q <= '0;
`ifdef BARREL_CTRL_FLAGS_EN
      out_zero_q  <= 1'b0;
      out_carry_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      opnd_q     <= opnd_d;
      cmd_q      <= cmd_d;
      out_data_q <= out_data_d;
      out_err_q  <= out_err_d;
      ops_done_q <= ops_done_d;
`ifdef BARREL_CTRL_FLAGS_EN
      out_zero_q  <= out_zero_d;
      out_carry_q <= out_carry_d;
`endif
    end
  end

  assign out_data = out_data_q;
  assign out_err  = out_err_q;
  assign ops_done = ops_done_q;
endmodule

// File: tb/tb_barrel_ctrl.sv
// Directed bench for barrel_ctrl (SETTLE=2, CNT_W=4); flag checks follow BARREL_CTRL_FLAGS_EN.

module tb_barrel_ctrl;
  localparam int Settle = 2;
  localparam int CntW   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_data;
  logic [2:0]      in_op;
  logic [4:0]      in_amt;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_data;
  logic            out_err;
  logic [CntW-1:0] ops_done;
`ifdef BARREL_CTRL_FLAGS_EN
  logic            out_zero;
  logic            out_carry;
`endif

  int checks = 0;
  int errors = 0;
  logic [CntW-1:0] exp_cnt = '0;

  barrel_ctrl #(.SETTLE(Settle), .CNT_W(CntW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_op    (in_op),
    .in_amt   (in_amt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_err  (out_err),
    .ops_done (ops_done)
`ifdef BARREL_CTRL_FLAGS_EN
    ,
    .out_zero (out_zero),
    .out_carry(out_carry)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full request/response transaction with the consumer stalling one cycle.
  task automatic run_op(input string tag, input logic [31:0] d, input logic [2:0] op,
                        input logic [4:0] amt, input logic [31:0] exp_d, input logic exp_e,
                        input logic exp_z, input logic exp_c);
    in_data   = d;
    in_op     = op;
    in_amt    = amt;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    chk({tag, "_in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    if (exp_e) begin
      chk({tag, "_lat_illegal"}, out_valid, 1);
    end else begin
      chk({tag, "_lat_early"}, out_valid, 0);
      repeat (Settle - 1) step();
      chk({tag, "_lat_settle"}, out_valid, 0);
      step();
      chk({tag, "_lat_done"}, out_valid, 1);
    end
    chk({tag, "_data"}, out_data, exp_d);
    chk({tag, "_err"}, out_err, exp_e);
    chk({tag, "_busy"}, in_ready, 0);
`ifdef BARREL_CTRL_FLAGS_EN
    chk({tag, "_zero"}, out_zero, exp_z);
    chk({tag, "_carry"}, out_carry, exp_c);
`else
    if (exp_z === 1'bx || exp_c === 1'bx) $display("note: unexpected flag value in %s", tag);
`endif
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    exp_cnt   = exp_cnt + 1'b1;
    chk({tag, "_ops_done"}, ops_done, exp_cnt);
    chk({tag, "_idle"}, in_ready, 1);
    chk({tag, "_valid_low"}, out_valid, 0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    in_op     = 3'b000;
    in_amt    = 5'd0;
    out_ready = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_ops_done", ops_done, 0);
    step();
    step();
    rst = 1'b0;
    step();

    // Main function across ops and boundaries.
    run_op("lsl4", 32'h0000_0001, 3'b000, 5'd4, 32'h0000_0010, 0, 0, 0);
    run_op("asr31", 32'h8000_0000, 3'b010, 5'd31, 32'hFFFF_FFFF, 0, 0, 0);
    run_op("lsr31", 32'h8000_0000, 3'b001, 5'd31, 32'h0000_0001, 0, 0, 0);
    run_op("ror1", 32'h0000_0001, 3'b100, 5'd1, 32'h8000_0000, 0, 0, 0);
    run_op("rol1", 32'h8000_0001, 3'b011, 5'd1, 32'h0000_0003, 0, 0, 0);
    run_op("lsl0", 32'hDEAD_BEEF, 3'b000, 5'd0, 32'hDEAD_BEEF, 0, 0, 0);
    run_op("lsr0", 32'hDEAD_BEEF, 3'b001, 5'd0, 32'hDEAD_BEEF, 0, 0, 0);
    run_op("asr0", 32'hDEAD_BEEF, 3'b010, 5'd0, 32'hDEAD_BEEF, 0, 0, 0);
    run_op("rol0", 32'hDEAD_BEEF, 3'b011, 5'd0, 32'hDEAD_BEEF, 0, 0, 0);
    run_op("ror0", 32'hDEAD_BEEF, 3'b100, 5'd0, 32'hDEAD_BEEF, 0, 0, 0);
    run_op("asr4_pos", 32'h7000_0000, 3'b010, 5'd4, 32'h0700_0000, 0, 0, 0);
    run_op("illegal7", 32'h1234_5678, 3'b111, 5'd3, 32'h0000_0000, 1, 1, 0);
    run_op("after_ill", 32'h0000_00F0, 3'b001, 5'd4, 32'h0000_000F, 0, 0, 0);
    run_op("illegal5", 32'hFFFF_FFFF, 3'b101, 5'd0, 32'h0000_0000, 1, 1, 0);

    // Consumer stall: output held, new request ignored.
    in_data  = 32'h0000_0001;
    in_op    = 3'b000;
    in_amt   = 5'd4;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("stall_enter_valid", out_valid, 1);
    in_data  = 32'hFFFF_FFFF;
    in_op    = 3'b001;
    in_amt   = 5'd1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", out_valid, 1);
      chk("stall_ready", in_ready, 0);
      chk("stall_data", out_data, 32'h0000_0010);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    exp_cnt   = exp_cnt + 1'b1;
    chk("stall_ops_done", ops_done, exp_cnt);
    chk("stall_idle", in_ready, 1);
    chk("stall_hold_data", out_data, 32'h0000_0010);

    // Reset mid-WAIT aborts the in-flight op.
    in_data  = 32'h0000_0001;
    in_op    = 3'b000;
    in_amt   = 5'd4;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("abort_in_wait", out_valid, 0);
    rst = 1'b1;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_ready", in_ready, 1);
    chk("abort_ops_done", ops_done, 0);
    exp_cnt = '0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_no_stale", out_valid, 0);
    end

    // 17 back-to-back ops with consumer always ready: counter wraps 16 -> 0 then 1.
    in_data   = 32'h0000_00F0;
    in_op     = 3'b100;
    in_amt    = 5'd4;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    repeat (Settle + 2) step();
    chk("tput_first", ops_done, 1);
    repeat (17 * (Settle + 2) - 1 - (Settle + 2)) step();
    chk("wrap_zero", ops_done, 0);
    chk("wrap_valid", out_valid, 1);
    chk("wrap_data", out_data, 32'h0000_000F);
    in_valid = 1'b0;
    step();
    chk("wrap_one", ops_done, 1);
    chk("wrap_idle", in_ready, 1);
    out_ready = 1'b0;
    exp_cnt   = 4'd1;

    // Carry/zero corner cases (data also checked without flags).
    run_op("lsl_carry", 32'h8000_0000, 3'b000, 5'd1, 32'h0000_0000, 0, 1, 1);
    run_op("lsr_carry", 32'h0000_0003, 3'b001, 5'd1, 32'h0000_0001, 0, 0, 1);
    run_op("lsl2_carry", 32'hC000_0000, 3'b000, 5'd2, 32'h0000_0000, 0, 1, 1);
    run_op("rol_nocarry", 32'h8000_0000, 3'b011, 5'd1, 32'h0000_0001, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
